// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding and default debounce length for key conditioning
package key_debounce_pkg;
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_state_t;
  localparam int DEBOUNCE_10MS_50MHZ = 500000;
endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw active-low keys in, debounced level and event pulses out
interface key_debounce_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] key_n;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  modport master (output key_n, input pressed, press_pulse, release_pulse);
  modport slave (input key_n, output pressed, press_pulse, release_pulse);
endinterface

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: synchronizer, stability FSM and registered outputs for one key
module key_debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  logic s1, s2, raw, done, press_nx, release_nx;
  key_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  assign raw = ~s2;
  assign done = cnt == CNT_W'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      state <= RELEASED;
      cnt <= '0;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      state <= state_nx;
      cnt <= cnt_nx;
      pressed <= state_nx inside {PRESSED, RELEASE_PENDING};
      press_pulse <= press_nx;
      release_pulse <= release_nx;
    end
  end
  // counter is compared before increment, so it tops out at STABLE_CYCLES-1
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    press_nx = 1'b0;
    release_nx = 1'b0;
    case (state)
      RELEASED: if (raw) begin
        state_nx = PRESS_PENDING;
        cnt_nx = CNT_W'(1);
      end
      PRESS_PENDING: if (!raw) state_nx = RELEASED;
      else if (done) begin
        state_nx = PRESSED;
        press_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      PRESSED: if (!raw) begin
        state_nx = RELEASE_PENDING;
        cnt_nx = CNT_W'(1);
      end
      RELEASE_PENDING: if (raw) state_nx = PRESSED;
      else if (done) begin
        state_nx = RELEASED;
        release_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      default: state_nx = RELEASED;
    endcase
  end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: WIDTH independent debounce channels for the board push-buttons
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input logic clk,
  input logic reset,
  key_debounce_if.slave kb
);
  logic [WIDTH-1:0] pressed, press_pulse, release_pulse;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk(clk),
      .reset(reset),
      .key_n(kb.key_n[i]),
      .pressed(pressed[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end
  assign kb.pressed = pressed;
  assign kb.press_pulse = press_pulse;
  assign kb.release_pulse = release_pulse;
endmodule
